if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction fetch stage directly upstream of control_unit.
- Owns the PC and issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface.
- Captures each returned instruction into the IF/ID register, whose opcode field drives control_unit.opcode.
- Accepts a PC redirect from branch/jump resolution (built from control_unit branch/jump/jal/jr) and supports downstream stall via a one-entry skid buffer.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  ADDR_W  fetch address, word aligned.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_resp_valid  input  1  instruction data valid (1 cycle pulse).
- imem_resp_data  input  DATA_W  returned instruction.
- redirect_valid  input  1  PC redirect request (taken branch/j/jal/jr).
- redirect_pc  input  ADDR_W  redirect target; bits[1:0] ignored.
- stall  input  1  decode cannot consume IF/ID this cycle.
- if_id_valid  output  1  IF/ID register holds a live instruction.
- if_id_instr  output  DATA_W  fetched instruction.
- if_id_opcode  output  6  if_id_instr[31:26], feeds control_unit.
- if_id_pc  output  ADDR_W  address of if_id_instr.
- if_id_pc_plus4  output  ADDR_W  if_id_pc+4, link value for jal.

Behaviour:
- Reset (async, any time):
  - state=IDLE, pc=RESET_PC, drop=0, skid empty.
  - if_id_valid=0, if_id_instr/pc/pc_plus4=0.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
- States:
  - IDLE: next cycle goes to REQ, so req_valid rises 1 cycle after reset deassert.
  - REQ: imem_req_valid=1, addr=pc. Handshake (valid&ready) moves to WAIT, pc<=pc+4 mod 2^ADDR_W, addr stays stable until the handshake.
  - WAIT: wait for imem_resp_valid.
    - If drop=1: discard the response, clear drop, go to REQ.
    - Else if slot free (!if_id_valid | !stall): load IF/ID, go to REQ.
    - Else: write the skid buffer and go to HOLD.
  - HOLD: no requests. When stall=0, IF/ID is consumed and the skid moves into IF/ID the same edge, then go to REQ.
- Consumption: IF/ID is consumed on an edge where if_id_valid & !stall. If nothing is loaded that edge, if_id_valid<=0.
- IF/ID capture:
  - if_id_instr=resp_data; if_id_pc=addr of that request (registered at handshake); if_id_pc_plus4=if_id_pc+4.
  - if_id_opcode is combinational from if_id_instr.
- Latency: handshake at cycle N, response at N+k, if_id_valid at N+k+1. Best-case throughput is 1 instruction per 2 cycles (single outstanding request).
- Redirect (priority over stall and all non-reset events), on its edge:
  - pc<={redirect_pc[ADDR_W-1:2],2'b00}; if_id_valid<=0; skid emptied.
  - REQ with no handshake: next request uses the new pc.
  - REQ with a handshake in the same cycle: the request counts, drop<=1, go to WAIT.
  - WAIT: drop<=1 unless imem_resp_valid is high the same cycle, in which case that response is discarded and the state goes to REQ.
  - HOLD: go to REQ.
  - IDLE: pc updated, go to REQ.
- Response arriving outside WAIT: ignored (protocol error, not flagged).
- Stall does not block requests in REQ. Only a full IF/ID plus a full skid (HOLD) stops fetching.
- PC wrap: 0xFFFF_FFFC+4 -> 0x0000_0000, no error.

Test Plan:
- Reset release, RESET_PC=0x0, ready=1, resp 1 cycle later with 0x00000020: req_valid rises 1 cycle after reset drop, addr 0x0, 0x4, 0x8. if_id_instr=0x00000020, if_id_pc=0x0, pc_plus4=0x4, if_id_opcode=6'b000000.
- imem_req_ready held 0 for 3 cycles: req_valid=1 and addr=0x4 stable all 3 cycles, pc not incremented until the handshake.
- stall=1 with IF/ID full, response 0x08000010 arrives: goes to HOLD, no new req_valid. stall drops: IF/ID=0x08000010 next edge (opcode 000010), REQ resumes at the next pc.
- Redirect to 0x00000103 while in WAIT: if_id_valid=0 next edge, the in-flight response is discarded, the next request addr=0x00000100, the following instruction carries if_id_pc=0x100.
- Redirect and handshake in the same cycle, plus redirect with stall=1 and the skid full: the stale response is dropped, the skid is flushed, the next request is at the redirect target.
- Assert reset in WAIT mid-fetch: all outputs return to reset values immediately (async). Fetch restarts at RESET_PC, and the late response during IDLE is ignored.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// fills the IF/ID register, with a one-entry skid buffer for decode stalls.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [5:0]        if_id_opcode,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus4
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_req_pc;
  logic                r_drop;
  logic [DATA_W-1:0]   r_skid_instr;
  logic [ADDR_W-1:0]   r_skid_pc;
  logic                r_id_valid;
  logic [DATA_W-1:0]   r_id_instr;
  logic [ADDR_W-1:0]   r_id_pc;
  logic [ADDR_W-1:0]   r_id_pc4;

  logic                w_consume;
  logic                w_slot_free;
  logic [ADDR_W-1:0]   w_redirect_pc;

  assign w_consume     = r_id_valid & ~stall;
  assign w_slot_free   = ~r_id_valid | ~stall;
  assign w_redirect_pc = redirect_pc & PC_MASK;

  // The skid buffer is full exactly while the FSM sits in HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_pc     <= '0;
      r_drop       <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_id_valid   <= 1'b0;
      r_id_instr   <= '0;
      r_id_pc      <= '0;
      r_id_pc4     <= '0;
    end else begin
      if (w_consume) r_id_valid <= 1'b0;
      if (redirect_valid) begin
        r_pc       <= w_redirect_pc;
        r_id_valid <= 1'b0;
        case (r_state)
          S_REQ: begin
            if (imem_req_ready) begin
              r_drop  <= 1'b1;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_drop <= 1'b1;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_REQ;
          S_REQ: begin
            if (imem_req_ready) begin
              r_req_pc <= r_pc;
              r_pc     <= r_pc + PC_STEP;
              r_state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              if (r_drop) begin
                r_drop  <= 1'b0;
                r_state <= S_REQ;
              end else if (w_slot_free) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_resp_data;
                r_id_pc    <= r_req_pc;
                r_id_pc4   <= r_req_pc + PC_STEP;
                r_state    <= S_REQ;
              end else begin
                r_skid_instr <= imem_resp_data;
                r_skid_pc    <= r_req_pc;
                r_state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_id_valid <= 1'b1;
              r_id_instr <= r_skid_instr;
              r_id_pc    <= r_skid_pc;
              r_id_pc4   <= r_skid_pc + PC_STEP;
              r_state    <= S_REQ;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign if_id_valid    = r_id_valid;
  assign if_id_instr    = r_id_instr;
  assign if_id_opcode   = r_id_instr[DATA_W-1 -: 6];
  assign if_id_pc       = r_id_pc;
  assign if_id_pc_plus4 = r_id_pc4;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a reactive memory model plus a program-order scoreboard
// that expects sequential PCs restarting at every redirect or reset.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [5:0]  if_id_opcode;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int          lat_fixed = 1;    // 0 selects a random latency 1..4
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;
  logic [31:0] mon_instr;
  int          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr;

  if_stage dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0020;
    if (a == 32'h8) return 32'h0800_0010;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 2048; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    if (redirect_valid && !reset) refill(redirect_pc & 32'hFFFF_FFFC);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'd0);
    check("rst_if_id_valid", 32'(if_id_valid), 32'd0);
    check("rst_if_id_instr", if_id_instr, 32'd0);
    check("rst_if_id_pc", if_id_pc, 32'd0);
    check("rst_if_id_pc_plus4", if_id_pc_plus4, 32'd0);
  endtask

  // Memory model: at most one request in flight, answers after a chosen latency.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      imem_resp_valid = 1'b0;
      if (pend != 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_fn(pend_addr);
          pend = 0;
        end
      end
      case (ready_mode)
        0:       imem_req_ready = ($urandom_range(0, 9) < 7);
        1:       imem_req_ready = 1'b1;
        default: imem_req_ready = 1'b0;
      endcase
      if (imem_req_valid && imem_req_ready && !reset) begin
        check("single_outstanding", 32'(pend), 32'd0);
        check("req_addr_aligned", 32'(imem_req_addr[1:0]), 32'd0);
        pend      = 1;
        pend_addr = imem_req_addr;
        pend_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      end
    end
  end

  // Monitor: every consumed IF/ID entry must be the next PC in program order.
  always @(negedge clk) begin
    if (!reset && if_id_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_underflow: got pc 0x%08h expected no instruction", if_id_pc);
      end else begin
        mon_pc    = exp_q.pop_front();
        mon_instr = mem_fn(mon_pc);
        check("if_id_pc", if_id_pc, mon_pc);
        check("if_id_instr", if_id_instr, mon_instr);
        check("if_id_pc_plus4", if_id_pc_plus4, mon_pc + 32'd4);
        check("if_id_opcode", 32'(if_id_opcode), 32'(mon_instr[31:26]));
        consumed++;
        $display("consume pc=%08h instr=%08h", if_id_pc, if_id_instr);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    refill(32'h0);
    repeat (3) tick();
    check_reset_outputs();

    // Reset release and first fetch
    reset = 1'b0;
    check("req_valid_at_release", 32'(imem_req_valid), 32'd0);
    tick();
    check("req_valid_rise", 32'(imem_req_valid), 32'd1);
    check("first_addr", imem_req_addr, 32'h0);
    tick();
    check("wait_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    check("first_valid", 32'(if_id_valid), 32'd1);
    check("first_instr", if_id_instr, 32'h0000_0020);
    check("first_pc", if_id_pc, 32'h0);
    check("first_pc4", if_id_pc_plus4, 32'h4);
    check("first_opcode", 32'(if_id_opcode), 32'd0);
    check("second_addr", imem_req_addr, 32'h4);

    // Memory not ready for three cycles
    ready_mode = 2;
    repeat (3) begin
      tick();
      check("noready_req_valid", 32'(imem_req_valid), 32'd1);
      check("noready_addr", imem_req_addr, 32'h4);
    end
    ready_mode = 1;
    tick();
    check("after_hs_addr", imem_req_addr, 32'h8);

    // Stall with IF/ID full pushes the next response into the skid buffer
    stall = 1'b1;
    tick();
    check("stall_load_pc", if_id_pc, 32'h4);
    tick();
    tick();
    check("hold_no_req", 32'(imem_req_valid), 32'd0);
    check("hold_id_pc", if_id_pc, 32'h4);
    tick();
    check("hold_no_req2", 32'(imem_req_valid), 32'd0);
    stall = 1'b0;
    tick();
    check("skid_instr", if_id_instr, 32'h0800_0010);
    check("skid_opcode", 32'(if_id_opcode), 32'd2);
    check("skid_pc", if_id_pc, 32'h8);
    check("resume_addr", imem_req_addr, 32'hC);

    // Redirect while waiting on a slow response
    lat_fixed = 3;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("redir_wait_flush", 32'(if_id_valid), 32'd0);
    tick();
    check("redir_wait_noreq", 32'(imem_req_valid), 32'd0);
    lat_fixed = 1;
    tick();
    check("redir_target_addr", imem_req_addr, 32'h100);
    check("redir_target_valid", 32'(imem_req_valid), 32'd1);
    tick();
    tick();
    check("redir_first_pc", if_id_pc, 32'h100);

    // Redirect in the same cycle as a handshake
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check("redir_hs_wait", 32'(imem_req_valid), 32'd0);
    tick();
    check("redir_hs_addr", imem_req_addr, 32'h200);

    // Redirect while stalled with the skid buffer full
    stall = 1'b1;
    repeat (4) tick();
    check("hold2_no_req", 32'(imem_req_valid), 32'd0);
    check("hold2_id_pc", if_id_pc, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    check("redir_hold_flush", 32'(if_id_valid), 32'd0);
    check("redir_hold_addr", imem_req_addr, 32'h300);
    stall = 1'b0;
    tick();
    tick();
    check("redir_hold_pc", if_id_pc, 32'h300);

    // Asynchronous reset mid-fetch; the late response lands in IDLE
    lat_fixed = 2;
    tick();
    #2 reset = 1'b1;
    refill(32'h0);
    #1;
    check_reset_outputs();
    tick();
    reset = 1'b0;
    lat_fixed = 1;
    tick();
    check("restart_req", 32'(imem_req_valid), 32'd1);
    check("restart_addr", imem_req_addr, 32'h0);
    check("restart_ignored_resp", 32'(if_id_valid), 32'd0);
    tick();
    tick();
    check("restart_instr", if_id_instr, 32'h0000_0020);

    // Randomized traffic, including redirects near the top of the address space
    ready_mode = 0;
    lat_fixed  = 0;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : ($urandom & 32'h0000_FFFF);
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    ready_mode = 1;
    repeat (20) tick();
    check("progress", 32'(consumed > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
